// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port signals of the fetch/data memory arbiter.
// The DUT takes the slave view; requesters and memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic                 i_grant;
  logic [WORD_SIZE-1:0] i_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic                 d_done;
  logic [WORD_SIZE-1:0] d_rdata;

  logic                 read_m;
  logic                 write_m;
  logic [WORD_SIZE-1:0] address;
  logic                 busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_grant, i_rdata, d_done, d_rdata, read_m, write_m, address, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_grant, i_rdata, d_done, d_rdata, read_m, write_m, address, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access,
// alternating on conflicts so neither requester starves.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    port_if,
  inout  wire  [WORD_SIZE-1:0] data
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;          // 1 = data requester
  logic                 last_owner_q, last_owner_d;
  logic                 we_q, we_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 pick_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    // On conflict the data side wins whenever fetch owned the port last.
    pick_d       = port_if.d_req && (!port_if.i_req || !last_owner_q);
    unique case (state_q)
      IDLE: begin
        if (port_if.i_req || port_if.d_req) begin
          owner_d      = pick_d;
          last_owner_d = pick_d;
          addr_d       = pick_d ? port_if.d_addr : port_if.i_addr;
          we_d         = pick_d && port_if.d_we;
          wdata_d      = port_if.d_wdata;
          cnt_d        = CNT_LOAD;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q) d_rdata_d = data;
            else         i_rdata_d = data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    port_if.read_m  = (state_q == ACCESS) && !we_q;
    port_if.write_m = (state_q == ACCESS) && we_q;
    port_if.address = addr_q;
    port_if.i_grant = (state_q == DONE) && !owner_q;
    port_if.d_done  = (state_q == DONE) && owner_q;
    port_if.busy    = (state_q != IDLE);
    port_if.i_rdata = i_rdata_q;
    port_if.d_rdata = d_rdata_q;
  end

  assign data = ((state_q == ACCESS) && we_q) ? wdata_q : {WORD_SIZE{1'bz}};
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single memory port (read_m/write_m/address/data) between the instruction-fetch requester and the data-access requester of the multi-cycle core. Each access is a fixed-latency transaction. The arbiter grants one requester at a time, holds address and control stable for the whole transaction, captures read data, and returns a one-cycle completion pulse to the owner. Conflicting requests alternate between the two requesters, so neither starves.

## Interface
- WORD_SIZE, 16, address/data width
- MEM_LATENCY, 2, cycles read_m/write_m is held per access; legal range 1..15
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; read-only; hold until i_grant
- i_addr  in  WORD_SIZE  fetch address
- i_grant  out  1  one-cycle pulse; fetch complete, i_rdata valid this cycle
- i_rdata  out  WORD_SIZE  fetched word; holds until next fetch completes
- d_req  in  1  data request; hold until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  write data
- d_done  out  1  one-cycle pulse; data access complete, d_rdata valid for reads
- d_rdata  out  WORD_SIZE  read word; holds until next data read completes
- read_m  out  1  memory read strobe
- write_m  out  1  memory write strobe
- address  out  WORD_SIZE  memory address
- data  inout  WORD_SIZE  memory bus; driven with latched wdata only while write_m=1, else high-Z
- busy  out  1  1 in ACCESS or DONE

## Operation
- FSM states:
  - IDLE: samples requests.
  - ACCESS: drives the memory port.
  - DONE: raises the completion pulse.
- IDLE arbitration:
  - If only one request is high, grant it.
  - If both are high, grant the requester opposite to last_owner. last_owner resets to I, so the first conflict goes to D.
  - If neither is high, stay in IDLE.
- On grant:
  - Latch owner, address, we (forced 0 for I), and wdata.
  - Load the counter with MEM_LATENCY-1, set last_owner to the new owner, and go to ACCESS.
- ACCESS:
  - address = latched address.
  - read_m = !we and write_m = we, both high for every ACCESS cycle.
  - The counter decrements each cycle.
  - On the edge leaving ACCESS with counter = 0, a read captures data into the owner's rdata register. Go to DONE.
- DONE:
  - Pulse i_grant or d_done for exactly one cycle.
  - read_m = write_m = 0. Requests are not sampled. Return to IDLE.
- Latched fields are immune to input changes after grant. Deasserting req mid-access does not abort; the access completes and done still pulses.
- A requester drops req (or presents a new request) at the edge where it samples done high. A req still high in the following IDLE cycle is a new request.
- The counter is 4 bits wide; no wrap occurs because it reloads only in IDLE.
- Reset (asynchronous, any state), taking effect immediately without a clock:
  - FSM goes to IDLE; last_owner = I.
  - read_m, write_m, i_grant, d_done, busy = 0; address, i_rdata, d_rdata = 0; data high-Z.
  - An access in flight is abandoned with no done pulse.

## Timing
- Request sampled high in IDLE at edge t0:
  - ACCESS occupies cycles t0+1 .. t0+MEM_LATENCY.
  - DONE (pulse) is cycle t0+MEM_LATENCY+1.
  - IDLE resumes at t0+MEM_LATENCY+2.
- Back-to-back throughput: one access per MEM_LATENCY+2 cycles, including one IDLE cycle between accesses.
- All outputs are registered or decoded from state only. There is no combinational path from any req input to read_m, write_m, or address.
- Write data is on the bus for the full ACCESS window. The bus goes high-Z in DONE.

## Test plan
- Reset: assert reset mid-simulation without a clock edge -> all outputs 0 and data high-Z immediately; after release, FSM stays in IDLE with busy=0 while no req is present.
- Single fetch, MEM_LATENCY=2, mem[0x0010]=0x1234: i_req with i_addr=0x0010 -> read_m=1 and address=0x0010 for 2 cycles, then i_grant=1 with i_rdata=0x1234 for 1 cycle; total 3 cycles from the sample edge.
- Data write then read: d_we=1, d_addr=0x0080, d_wdata=0xBEEF -> write_m held 2 cycles with data=0xBEEF, then d_done; then d_we=0 at 0x0080 -> d_rdata=0xBEEF with d_done.
- Contention: i_req and d_req both held continuously from reset -> grant order D, I, D, I; each access separated by exactly one IDLE cycle.
- Abort by reset: reset asserted during the 2nd ACCESS cycle of a read -> read_m falls asynchronously with no d_done; after release with d_req still high, a fresh full-length access runs and d_done pulses exactly once.
- Early drop: i_req deasserted during the 1st ACCESS cycle -> access still runs 2 cycles, i_grant pulses once, and no further access starts.
